// File: rtl/pipe_mdu_if.sv
// EX-stage <-> multiply/divide unit bundle: operands, HI/LO moves and hazard signals.
interface pipe_mdu_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        mf_req;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (output start, op, ea, eb, mf_req, mthi, mtlo,
                  input  hi, lo, busy, stall, done);
  modport slave  (input  start, op, ea, eb, mf_req, mthi, mtlo,
                  output hi, lo, busy, stall, done);
endinterface

// File: rtl/pipe_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 1 accept edge, 32 RUN edges, 1 FIX edge.
// Operands are reduced to magnitudes up front; signs are reapplied in FIX.
module pipe_mdu (
  input  logic      clock,
  input  logic      resetn,
  pipe_mdu_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic        r_div;      // 1: divide, 0: multiply
  logic        r_neg_lo;   // product / quotient needs negating
  logic        r_neg_hi;   // remainder takes dividend sign
  logic        r_dz;       // divide by zero seen at accept
  logic [31:0] r_m;        // multiplicand (mult) or divisor (div) magnitude
  logic [31:0] r_dvd;      // raw dividend, returned in HI on divide by zero
  logic [63:0] r_acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] r_hi, r_lo;
  logic        r_done;

  // operand conditioning at accept
  logic        w_signed, w_sa, w_sb;
  logic [31:0] w_abs_a, w_abs_b;
  assign w_signed = ~bus.op[0];
  assign w_sa     = w_signed & bus.ea[31];
  assign w_sb     = w_signed & bus.eb[31];
  assign w_abs_a  = w_sa ? -bus.ea : bus.ea;
  assign w_abs_b  = w_sb ? -bus.eb : bus.eb;

  // radix-2 shift-add: add multiplicand on LSB, then shift the 65-bit {carry,acc} right
  logic [32:0] w_add;
  logic [63:0] w_mstep;
  assign w_add   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
  assign w_mstep = {w_add, r_acc[31:1]};

  // restoring divide: shift next dividend bit into remainder, subtract if it fits
  logic [32:0] w_shl;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [63:0] w_dstep;
  assign w_shl   = {r_acc[63:32], r_acc[31]};
  assign w_ge    = (w_shl >= {1'b0, r_m});
  assign w_sub   = w_shl[31:0] - r_m;   // true difference is < 2^32 whenever w_ge
  assign w_dstep = {(w_ge ? w_sub : w_shl[31:0]), r_acc[30:0], w_ge};

  // sign fix-up of the finished result
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;
  assign w_prod = r_neg_lo ? -r_acc : r_acc;
  assign w_quo  = r_neg_lo ? -r_acc[31:0]  : r_acc[31:0];
  assign w_rem  = r_neg_hi ? -r_acc[63:32] : r_acc[63:32];

  // state register
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // datapath: latch operands, iterate, write HI/LO
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      r_m      <= '0;
      r_dvd    <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_div    <= bus.op[1];
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= w_sa;
            r_dz     <= bus.op[1] & (bus.eb == 32'd0);
            r_m      <= bus.op[1] ? w_abs_b : w_abs_a;
            r_acc    <= {32'd0, (bus.op[1] ? w_abs_a : w_abs_b)};
            r_dvd    <= bus.ea;
            r_cnt    <= '0;
          end else begin
            if (bus.mthi) r_hi <= bus.ea;
            if (bus.mtlo) r_lo <= bus.ea;
          end
        end
        S_RUN: begin
          r_acc <= r_div ? w_dstep : w_mstep;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (!r_div) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end else if (r_dz) begin
            r_hi <= r_dvd;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.done  = r_done;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.mf_req | bus.mthi | bus.mtlo);
endmodule

// File: tb/tb_pipe_mdu.sv
// Scoreboard bench for pipe_mdu: issued ops push expected HI/LO, a monitor checks on done.
module tb_pipe_mdu;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  pipe_mdu_if bus();
  pipe_mdu dut (.clock(clock), .resetn(resetn), .bus(bus));

  typedef struct { logic [63:0] res; int e0; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2, q, r;
    longint unsigned ua, ub, uq, ur;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      2'd0: return sa * sb2;
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb2; r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub; ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Monitor: every done pulse pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (resetn && bus.done) begin
      if (sb.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("hi", bus.hi, e.res[63:32]);
        chk("lo", bus.lo, e.res[31:0]);
        chk("latency", cyc - e.e0, 33);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (bus.busy && n < 200) begin @(negedge clock); n++; end
    if (bus.busy) chk("idle_timeout", 1, 0);
  endtask

  // Issue one op; hz=1 raises mf_req during RUN and expects stall throughout.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hz);
    int n = 0, bad = 0;
    exp_t e;
    wait_idle();
    bus.start = 1; bus.op = op; bus.ea = a; bus.eb = b;
    @(posedge clock); #1;
    e.res = model(op, a, b); e.e0 = cyc; sb.push_back(e);
    bus.start = 0;
    if (hz) bus.mf_req = 1;
    @(negedge clock);
    while (bus.busy && n < 100) begin
      if (bus.stall !== hz) bad++;
      n++;
      @(negedge clock);
    end
    chk("busy_cycles", n, 33);
    chk("stall_run", bad, 0);
    chk("stall_idle", bus.stall, 0);
    bus.mf_req = 0;
  endtask

  // Second op held on start while the first runs: stall every cycle, accept at E34.
  task automatic b2b(input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                     input logic [1:0] op2, input logic [31:0] a2, input logic [31:0] b2);
    int n = 0, bad = 0, t0;
    exp_t e;
    wait_idle();
    bus.start = 1; bus.op = op1; bus.ea = a1; bus.eb = b1;
    @(posedge clock); #1;
    t0 = cyc; e.res = model(op1, a1, b1); e.e0 = t0; sb.push_back(e);
    bus.op = op2; bus.ea = a2; bus.eb = b2;
    @(negedge clock);
    while (bus.busy && n < 100) begin
      if (!bus.stall) bad++;
      n++;
      @(negedge clock);
    end
    chk("b2b_stall", bad, 0);
    chk("b2b_busy", n, 33);
    @(posedge clock); #1;
    e.res = model(op2, a2, b2); e.e0 = cyc; sb.push_back(e);
    chk("b2b_accept", cyc - t0, 34);
    bus.start = 0;
    wait_idle();
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    logic [1:0] op;
    bus.start = 0; bus.op = 0; bus.ea = 0; bus.eb = 0;
    bus.mf_req = 0; bus.mthi = 0; bus.mtlo = 0;
    repeat (3) @(negedge clock);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    resetn = 1;

    // directed cases
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(2'd0, 32'hFFFF_FFFD, 32'd5, 0);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000, 0);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1);
    issue(2'd3, 32'd7, 32'd2, 0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 0);
    issue(2'd2, 32'hFFFF_FFF0, 32'd0, 0);
    issue(2'd3, 32'h0000_1234, 32'd0, 0);

    // HI/LO moves in IDLE
    wait_idle();
    bus.mf_req = 1; #1;
    chk("mf_idle_stall", bus.stall, 0);
    bus.mf_req = 0;
    bus.mthi = 1; bus.ea = 32'hCAFE_BABE; #1;
    chk("mthi_stall", bus.stall, 0);
    @(posedge clock); #1;
    bus.mthi = 0;
    chk("mthi_hi", bus.hi, 32'hCAFE_BABE);
    chk("mthi_lo_kept", bus.lo, 32'hFFFF_FFFF);
    @(negedge clock);
    bus.mtlo = 1; bus.ea = 32'h1357_9BDF;
    @(posedge clock); #1;
    bus.mtlo = 0;
    chk("mtlo_lo", bus.lo, 32'h1357_9BDF);

    b2b(2'd0, 32'd12345, 32'hFFFF_FF00, 2'd3, 32'hDEAD_BEEF, 32'd1000);

    // randomized mix
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(0, 9));
        1: a = 32'($urandom_range(0, 300));
        2: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b, bit'($urandom_range(0, 1)));
    end

    // reset in the middle of an operation
    wait_idle();
    bus.start = 1; bus.op = 2'd0; bus.ea = 32'd3; bus.eb = 32'd5;
    @(posedge clock); #1;
    bus.start = 0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    resetn = 0;
    @(posedge clock); #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    chk("midrst_done", bus.done, 0);
    @(negedge clock);
    resetn = 1;
    n = 0;
    repeat (40) begin @(negedge clock); if (bus.done || bus.busy) n++; end
    chk("midrst_quiet", n, 0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clock); n++; end
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_mdu.md
# pipe_mdu

Multi-cycle multiply/divide unit for the EX stage of the 5-stage pipelined CPU. It consumes the operand pair (`ea`, `eb`) and the op code that the ID/EX pipeline register delivers. It computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over a fixed 33-cycle latency. It drives a stall request back to the hazard logic while busy so that later MDU instructions and HI/LO reads hold in EX.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  EX holds a valid (non-bubble) MULT/MULTU/DIV/DIVU; level, held by pipeline while stalled.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `ea`  in  32  rs operand (multiplicand/dividend).
- `eb`  in  32  rt operand (multiplier/divisor).
- `mf_req`  in  1  EX holds MFHI/MFLO.
- `mthi`, `mtlo`  in  1 each  EX holds MTHI/MTLO; write data is `ea`.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.
- `busy`  out  1  state != IDLE (combinational from state).
- `stall`  out  1  busy & (start | mf_req | mthi | mtlo).
- `done`  out  1  registered one-cycle pulse when HI/LO receive a new result.

## Operation
- FSM states: IDLE, RUN, FIX; 5-bit iteration counter `cnt`.
- IDLE + `start` at edge E0:
  - latch `op`; latch |ea|, |eb| (magnitudes for signed ops, raw for unsigned); latch sign flags.
  - `cnt`=0, go to RUN.
- RUN: one bit per cycle; at `cnt`==31 go to FIX, else `cnt`+1.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring, 32-bit partial remainder, one quotient bit per cycle.
- FIX: sign correction, write HI/LO, go to IDLE.
  - Multiply, signed with differing signs: 64-bit two's-complement negate; HI = [63:32], LO = [31:0].
  - Divide: LO = quotient, negated if signed and signs differ; HI = remainder, taking the dividend's sign.
- Divide by zero (detected at E0, result overridden in FIX, latency unchanged): LO = 0xFFFFFFFF, HI = dividend unmodified.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (natural 32-bit wrap, no trap).
- MTHI/MTLO in IDLE: `hi`/`lo` <= `ea` at next edge. If `start` is also asserted, `start` wins and the write is ignored (the pipeline never issues both).
- While not IDLE: `start`, `mf_req`, `mthi`, `mtlo` are not acted on; `stall` holds them in EX. `hi`/`lo` keep their old values until FIX.
- No abort input. The pipeline flushes only instructions younger than the one occupying the MDU.

## Timing
- Reset (synchronous, `resetn`=0 at an edge):
  - state IDLE, `cnt`=0, `hi`=`lo`=0, `done`=0, internal accumulators 0.
  - Reset mid-operation discards the operation; `busy`=0 after that edge.
- Latency: acceptance edge E0; RUN occupies E1–E32; FIX result at E33.
  - At E33: `hi`/`lo` updated, `done`=1 for one cycle, state IDLE.
  - `busy` is high for the cycles E0→E33 (33 cycles).
- Back-to-back: a `start` held by the pipeline is accepted at E34, the first edge at which state is IDLE. Issue rate is one operation per 34 cycles.
- `stall` is combinational, so hazard logic sees it in the same cycle the conflicting instruction arrives in EX.
- `mf_req` in IDLE: no stall; `hi`/`lo` are read directly, so the value written at E33 is visible in the cycle after E33.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulse exactly 33 edges after acceptance, `busy` high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> `hi`=0x40000000, `lo`=0.
- DIV −7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7 / 2 -> `lo`=3, `hi`=1. DIV 0x80000000 / −1 -> `lo`=0x80000000, `hi`=0.
- DIVU 0x1234 / 0 -> `lo`=0xFFFFFFFF, `hi`=0x1234, same 33-cycle latency.
- Hazards:
  - hold `start` for a second op during RUN -> `stall`=1 every cycle until IDLE; second op accepted at E34.
  - `mf_req` during RUN -> `stall`=1 until IDLE.
  - `mthi` 0xCAFEBABE in IDLE -> `hi`=0xCAFEBABE next edge, `stall`=0.
- Start MULT, assert `resetn`=0 at E10 -> after that edge `busy`=0, `hi`=`lo`=0, no `done` pulse.
